// File: rtl/kyber_codec_pkg.sv
// Shared constants, op encoding and job descriptor for the Kyber codec engine.
// No ports. Imported by kyber_codec_lane and kyber_codec_engine.
package kyber_codec_pkg;
   localparam int Q              = 3329;
   localparam int COEF_W         = 12;
   localparam int LANES          = 8;
   localparam int WORDS_PER_POLY = 32;
   localparam int WORD_W         = COEF_W * LANES;
   // poly_cnt is 3 bits, so a job never exceeds 7*32 = 224 words
   localparam int JOB_CNT_W      = 8;

   typedef enum logic [1:0] {
      OP_PACK12     = 2'd0,
      OP_UNPACK12   = 2'd1,
      OP_COMPRESS   = 2'd2,
      OP_DECOMPRESS = 2'd3
   } op_e;

   typedef struct packed {
      op_e                  op;
      logic [3:0]           dd;     // effective lane width: d, or 12 for ops 0/1
      logic [JOB_CNT_W-1:0] words;
   } job_t;

   function automatic logic d_legal(input logic [3:0] d);
      return (d == 4'd1) || (d == 4'd4) || (d == 4'd5) || (d == 4'd10) || (d == 4'd11);
   endfunction
endpackage

// File: rtl/kyber_codec_lane.sv
// Single-coefficient datapath: Compress_d, Decompress_d or pass-through, plus
// the >= Q range flag used by UNPACK12.
// Ports: op (job op), dd (lane width), x (coefficient in), y (result),
//        range_err (x >= Q).
module kyber_codec_lane
   import kyber_codec_pkg::*;
(
   input  op_e               op,
   input  logic [3:0]        dd,
   input  logic [COEF_W-1:0] x,
   output logic [COEF_W-1:0] y,
   output logic              range_err
);
   logic [COEF_W-1:0] mask;
   logic [COEF_W-1:0] xr;
   logic [23:0]       num;
   logic [23:0]       prod;

   always_comb begin
      mask      = COEF_W'((13'd1 << dd) - 13'd1);
      range_err = (x >= COEF_W'(Q));
      // single conditional subtract is enough: x < 2*Q for any 12-bit input
      xr        = range_err ? x - COEF_W'(Q) : x;
      num       = (24'(xr) << dd) + 24'd1664;
      prod      = 24'(x & mask) * 24'(Q) + (24'd1 << (dd - 4'd1));
      case (op)
         OP_COMPRESS:   y = COEF_W'(num / 24'(Q)) & mask;
         OP_DECOMPRESS: y = COEF_W'(prod >> dd);
         default:       y = x;
      endcase
   end
endmodule

// File: rtl/kyber_codec_engine.sv
// Streams whole polynomials between the 8x12-bit coefficient RAM and a packed
// valid/ready group stream, applying PACK12 / UNPACK12 / Compress_d /
// Decompress_d per job.
// Ports: clk, rst (sync, high); start/op/d/base_addr/poly_cnt job request;
//        busy/done/cfg_err/err_range status; ram_* read and write ports
//        (read data one cycle after address); s_in_* packed input stream;
//        s_out_* packed output stream.
module kyber_codec_engine
   import kyber_codec_pkg::*;
#(
   parameter int RAM_AW     = 8,
   parameter int MAX_POLYS  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [3:0]        d,
   input  logic [RAM_AW-1:0] base_addr,
   input  logic [2:0]        poly_cnt,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              err_range,
   output logic [RAM_AW-1:0] ram_raddr,
   input  logic [WORD_W-1:0] ram_rdata,
   output logic              ram_wen,
   output logic [RAM_AW-1:0] ram_waddr,
   output logic [WORD_W-1:0] ram_wdata,
   input  logic              s_in_valid,
   output logic              s_in_ready,
   input  logic [WORD_W-1:0] s_in_data,
   output logic              s_out_valid,
   input  logic              s_out_ready,
   output logic [WORD_W-1:0] s_out_data
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} state_e;

   state_e                          state;
   job_t                            job;
   logic [RAM_AW-1:0]               base_q;
   logic [JOB_CNT_W-1:0]            issued, sent, accepted;
   logic [1:0]                      vld_pipe;   // [0]: rdata valid, [1]: stage_q valid
   logic [WORD_W-1:0]               stage_q;
   logic [FIFO_DEPTH-1:0][WORD_W-1:0] fifo_mem;
   logic [PTR_W-1:0]                wr_ptr, rd_ptr;
   logic [FCNT_W-1:0]               fifo_cnt;

   logic [LANES-1:0][COEF_W-1:0]    lane_in, lane_out;
   logic [LANES-1:0]                lane_rerr;
   logic [COEF_W-1:0]               dmask;
   logic [WORD_W-1:0]               pack_out;
   logic                            is_wr, rd_en, push, pop, illegal;

   assign is_wr       = (job.op == OP_UNPACK12) || (job.op == OP_DECOMPRESS);
   assign dmask       = COEF_W'((13'd1 << job.dd) - 13'd1);
   // credit covers words already in the FIFO plus both pipeline slots
   assign rd_en       = (state == S_RUN) && !is_wr && (issued < job.words) &&
                        (int'(fifo_cnt) + int'(vld_pipe[0]) + int'(vld_pipe[1]) < FIFO_DEPTH);
   assign push        = vld_pipe[1];
   assign s_out_valid = (fifo_cnt != '0);
   assign s_out_data  = fifo_mem[rd_ptr];
   assign pop         = s_out_valid && s_out_ready;
   assign s_in_ready  = (state == S_RUN) && is_wr && (accepted < job.words);
   assign ram_raddr   = base_q + RAM_AW'(issued);
   assign illegal     = (job.words == '0) ||
                        (int'(job.words) > MAX_POLYS * WORDS_PER_POLY) ||
                        (!is_wr && job.op == OP_COMPRESS && !d_legal(job.dd)) ||
                        (job.op == OP_DECOMPRESS && !d_legal(job.dd));

   // lane input: raw RAM word for read ops, unpacked dd-bit groups for write ops
   always_comb begin
      logic [6:0] sh;
      lane_in = ram_rdata;
      sh      = '0;
      if (is_wr)
         for (int j = 0; j < LANES; j++) begin
            sh         = 7'(j) * {3'd0, job.dd};
            lane_in[j] = COEF_W'(s_in_data >> sh) & dmask;
         end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      kyber_codec_lane u_lane (
         .op        (job.op),
         .dd        (job.dd),
         .x         (lane_in[j]),
         .y         (lane_out[j]),
         .range_err (lane_rerr[j])
      );
   end

   always_comb begin
      logic [6:0] sh;
      pack_out = '0;
      sh       = '0;
      for (int j = 0; j < LANES; j++) begin
         sh       = 7'(j) * {3'd0, job.dd};
         pack_out = pack_out | (WORD_W'(lane_out[j] & dmask) << sh);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         job       <= '0;
         base_q    <= '0;
         issued    <= '0;
         sent      <= '0;
         accepted  <= '0;
         vld_pipe  <= '0;
         stage_q   <= '0;
         fifo_mem  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         err_range <= 1'b0;
         ram_wen   <= 1'b0;
         ram_waddr <= '0;
         ram_wdata <= '0;
      end else begin
         done     <= 1'b0;
         ram_wen  <= 1'b0;
         vld_pipe <= {vld_pipe[0], rd_en};
         if (rd_en)       issued  <= issued + 1'b1;
         if (vld_pipe[0]) stage_q <= pack_out;
         if (push) begin
            fifo_mem[wr_ptr] <= stage_q;
            wr_ptr <= (int'(wr_ptr) == FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (int'(rd_ptr) == FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            sent   <= sent + 1'b1;
         end
         fifo_cnt <= fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);

         // the write-side lane stage is the RAM write port register itself
         if (s_in_ready && s_in_valid) begin
            accepted  <= accepted + 1'b1;
            ram_wen   <= 1'b1;
            ram_waddr <= base_q + RAM_AW'(accepted);
            ram_wdata <= lane_out;
            if (job.op == OP_UNPACK12 && |lane_rerr) err_range <= 1'b1;
         end

         case (state)
            S_IDLE: if (start) begin
               state     <= S_CHECK;
               busy      <= 1'b1;
               cfg_err   <= 1'b0;
               err_range <= 1'b0;
               job.op    <= op_e'(op);
               job.dd    <= op[1] ? d : 4'd12;
               job.words <= JOB_CNT_W'(poly_cnt) * JOB_CNT_W'(WORDS_PER_POLY);
               base_q    <= base_addr;
               issued    <= '0;
               sent      <= '0;
               accepted  <= '0;
            end
            S_CHECK: begin
               if (illegal) begin
                  cfg_err <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_FIN;
               end else begin
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               // write ops: accepted hits words exactly in the last ram_wen cycle
               if (is_wr ? (accepted == job.words)
                         : (pop && sent == job.words - 1'b1)) begin
                  done  <= 1'b1;
                  state <= S_FIN;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_kyber_codec_engine.sv
module tb_kyber_codec_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [3:0]  d = '0;
   logic [7:0]  base_addr = '0;
   logic [2:0]  poly_cnt = '0;
   logic        busy, done, cfg_err, err_range;
   logic [7:0]  ram_raddr, ram_waddr;
   logic [95:0] ram_rdata = '0;
   logic        ram_wen;
   logic [95:0] ram_wdata;
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [95:0] s_in_data = '0;
   logic        s_out_valid;
   logic        s_out_ready = 1'b0;
   logic [95:0] s_out_data;

   kyber_codec_engine #(.RAM_AW(8), .MAX_POLYS(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .d(d), .base_addr(base_addr),
      .poly_cnt(poly_cnt), .busy(busy), .done(done), .cfg_err(cfg_err),
      .err_range(err_range), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
      .s_out_valid(s_out_valid), .s_out_ready(s_out_ready), .s_out_data(s_out_data)
   );

   always #5 clk = ~clk;

   // RAM model with a bench-side preload port
   logic [95:0] mem [256];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_addr = '0;
   logic [95:0] tb_data = '0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      ram_rdata <= mem[ram_raddr];
      if (tb_we)   mem[tb_addr]   <= tb_data;
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
   end

   // monitor logs, sampled mid-cycle
   logic [95:0] hs_log [1024];
   int          hs_cyc_log [1024];
   logic [7:0]  wr_addr_log [1024];
   logic [95:0] wr_data_log [1024];
   int hs_total = 0, wr_total = 0, done_total = 0, done_cyc = 0;

   always @(negedge clk) begin
      if (s_out_valid && s_out_ready) begin
         hs_log[hs_total % 1024]     <= s_out_data;
         hs_cyc_log[hs_total % 1024] <= cyc;
         hs_total                    <= hs_total + 1;
      end
      if (ram_wen) begin
         wr_addr_log[wr_total % 1024] <= ram_waddr;
         wr_data_log[wr_total % 1024] <= ram_wdata;
         wr_total                     <= wr_total + 1;
      end
      if (done) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
      end
   end

   int n_chk = 0, n_fail = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ram_fill(input logic [7:0] b, input int n, input logic [95:0] w, input bit inc);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         tb_we = 1'b1; tb_addr = b + 8'(i); tb_data = inc ? w + 96'(i) : w;
      end
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   task automatic start_job(input logic [1:0] o, input logic [3:0] dv, input logic [7:0] b,
                            input logic [2:0] pc, output int c);
      @(posedge clk); #1;
      op = o; d = dv; base_addr = b; poly_cnt = pc; start = 1'b1; c = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({busy, done, cfg_err, err_range, ram_wen, s_in_ready, s_out_valid} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {busy, done, cfg_err, err_range, ram_wen, s_in_ready, s_out_valid});
      end
      n_chk++;
      if (ram_raddr !== 8'h0 || ram_waddr !== 8'h0 || ram_wdata !== 96'h0 || s_out_data !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_data: raddr=%h waddr=%h wdata=%h odata=%h want all 0",
                  ram_raddr, ram_waddr, ram_wdata, s_out_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_compress_d10;
      int c, h0, w0, dn0, bad; bit to;
      logic [95:0] exp_w;
      exp_w = '0;
      for (int j = 0; j < 8; j++) exp_w = exp_w | (96'h200 << (j * 10));
      ram_fill(8'h00, 32, {8{12'd1665}}, 1'b0);
      s_out_ready = 1'b1;
      h0 = hs_total; w0 = wr_total; dn0 = done_total;
      start_job(2'd2, 4'd10, 8'h00, 3'd1, c);
      wait_done(300, to);
      @(posedge clk); #1;
      s_out_ready = 1'b0;
      n_chk++;
      if (to) begin n_fail++; $display("FAIL c10_timeout: done not seen within 300 cycles"); end
      n_chk++;
      if (hs_total - h0 != 32) begin n_fail++; $display("FAIL c10_count: got %0d want 32", hs_total - h0); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (hs_log[(h0 + i) % 1024] !== exp_w) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL c10_data: %0d words differ, first=%h want %h", bad, hs_log[h0 % 1024], exp_w); end
      n_chk++;
      if (hs_cyc_log[h0 % 1024] != c + 5) begin n_fail++; $display("FAIL c10_latency: first valid cycle %0d want %0d", hs_cyc_log[h0 % 1024], c + 5); end
      n_chk++;
      if (hs_cyc_log[(h0 + 31) % 1024] - hs_cyc_log[h0 % 1024] != 31) begin
         n_fail++; $display("FAIL c10_throughput: span %0d want 31", hs_cyc_log[(h0 + 31) % 1024] - hs_cyc_log[h0 % 1024]);
      end
      n_chk++;
      if (done_cyc != hs_cyc_log[(h0 + 31) % 1024] + 1) begin
         n_fail++; $display("FAIL c10_done_time: done at %0d want %0d", done_cyc, hs_cyc_log[(h0 + 31) % 1024] + 1);
      end
      n_chk++;
      if (done_total - dn0 != 1) begin n_fail++; $display("FAIL c10_done_pulses: got %0d want 1", done_total - dn0); end
      n_chk++;
      if (wr_total != w0 || ram_raddr !== 8'd32) begin
         n_fail++; $display("FAIL c10_ram: writes=%0d reads=%0d want 0 and 32", wr_total - w0, ram_raddr);
      end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL c10_busy: got %b want 0", busy); end
   endtask

   task automatic test_compress_d1;
      int c, h0, bad; bit to;
      ram_fill(8'h20, 32, {12'd4095, 12'd1664, 12'd3328, 12'd0, 12'd2497, 12'd2496, 12'd833, 12'd832}, 1'b0);
      s_out_ready = 1'b1;
      h0 = hs_total;
      start_job(2'd2, 4'd1, 8'h20, 3'd1, c);
      wait_done(300, to);
      @(posedge clk); #1;
      s_out_ready = 1'b0;
      n_chk++;
      if (to || hs_total - h0 != 32) begin n_fail++; $display("FAIL c1_count: timeout=%0d words=%0d want 0 and 32", to, hs_total - h0); end
      n_chk++;
      if (hs_log[h0 % 1024] !== 96'h46) begin n_fail++; $display("FAIL c1_first: got %h want 46", hs_log[h0 % 1024]); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (hs_log[(h0 + i) % 1024] !== 96'h46) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL c1_all: %0d words differ from 46", bad); end
   endtask

   task automatic test_decompress_wrap;
      int c, w0, h0, bad_d, bad_a; bit to;
      ram_fill(8'hEF, 1, 96'hDEAD, 1'b0);
      ram_fill(8'h50, 1, 96'hDEAD, 1'b0);
      w0 = wr_total; h0 = hs_total;
      s_in_data  = 96'hABCD_0000_0000_0000_0000_001F;
      s_in_valid = 1'b1;
      start_job(2'd3, 4'd4, 8'hF0, 3'd3, c);
      wait_done(400, to);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      n_chk++;
      if (to || wr_total - w0 != 96) begin n_fail++; $display("FAIL dec_count: timeout=%0d writes=%0d want 0 and 96", to, wr_total - w0); end
      bad_d = 0; bad_a = 0;
      for (int i = 0; i < 96; i++) begin
         if (wr_data_log[(w0 + i) % 1024] !== 96'h0D0C31) bad_d++;
         if (wr_addr_log[(w0 + i) % 1024] !== 8'(8'hF0 + i)) bad_a++;
      end
      n_chk++;
      if (bad_d != 0) begin n_fail++; $display("FAIL dec_data: %0d words differ, first=%h want 0d0c31", bad_d, wr_data_log[w0 % 1024]); end
      n_chk++;
      if (bad_a != 0) begin n_fail++; $display("FAIL dec_addr: %0d addresses out of sequence", bad_a); end
      n_chk++;
      if (wr_addr_log[(w0 + 15) % 1024] !== 8'hFF || wr_addr_log[(w0 + 16) % 1024] !== 8'h00) begin
         n_fail++; $display("FAIL dec_wrap: got %h,%h want ff,00", wr_addr_log[(w0 + 15) % 1024], wr_addr_log[(w0 + 16) % 1024]);
      end
      n_chk++;
      if (mem[8'hEF] !== 96'hDEAD || mem[8'h50] !== 96'hDEAD || mem[8'h4F] !== 96'h0D0C31) begin
         n_fail++; $display("FAIL dec_mem: ef=%h 50=%h 4f=%h want dead dead 0d0c31", mem[8'hEF], mem[8'h50], mem[8'h4F]);
      end
      n_chk++;
      if (hs_total != h0 || ram_raddr !== 8'hF0) begin n_fail++; $display("FAIL dec_noread: outs=%0d raddr=%h want 0 f0", hs_total - h0, ram_raddr); end
   endtask

   task automatic test_unpack_range;
      int c, w0, bad; bit to;
      logic [95:0] w;
      w = 96'h123 | (96'hD01 << 36);
      w0 = wr_total;
      s_in_data  = w;
      s_in_valid = 1'b1;
      start_job(2'd1, 4'd0, 8'h40, 3'd1, c);
      wait_done(200, to);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      n_chk++;
      if (to || wr_total - w0 != 32) begin n_fail++; $display("FAIL unp_count: timeout=%0d writes=%0d want 0 and 32", to, wr_total - w0); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (wr_data_log[(w0 + i) % 1024] !== w) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL unp_data: %0d words altered, first=%h want %h", bad, wr_data_log[w0 % 1024], w); end
      n_chk++;
      if (err_range !== 1'b1 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL unp_err: err_range=%b cfg_err=%b want 1 0", err_range, cfg_err); end
      repeat (5) @(posedge clk);
      #1;
      n_chk++;
      if (err_range !== 1'b1) begin n_fail++; $display("FAIL unp_sticky: err_range=%b want 1", err_range); end
   endtask

   task automatic test_back_to_back_pack12;
      int c, h0, bad, viol, iss; bit to;
      ram_fill(8'h80, 32, 96'h0AB0CD0EF012034056078000, 1'b1);
      h0 = hs_total;
      s_out_ready = 1'b0;
      start_job(2'd0, 4'd7, 8'h80, 3'd1, c);
      n_chk++;
      if (err_range !== 1'b0) begin n_fail++; $display("FAIL p12_errclr: err_range=%b want 0", err_range); end
      viol = 0; to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         iss = int'(8'(ram_raddr - 8'h80));
         if (iss > hs_total - h0 + 4) viol++;
         s_out_ready = (cyc % 3 == 0);
         if (done) begin to = 1'b0; break; end
      end
      s_out_ready = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (to || hs_total - h0 != 32) begin n_fail++; $display("FAIL p12_count: timeout=%0d words=%0d want 0 and 32", to, hs_total - h0); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (hs_log[(h0 + i) % 1024] !== 96'h0AB0CD0EF012034056078000 + 96'(i)) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL p12_order: %0d words wrong, first=%h", bad, hs_log[h0 % 1024]); end
      n_chk++;
      if (viol != 0) begin n_fail++; $display("FAIL p12_credit: %0d cycles with reads > handshakes+4", viol); end
      n_chk++;
      if (ram_raddr !== 8'hA0) begin n_fail++; $display("FAIL p12_reads: raddr=%h want a0", ram_raddr); end
   endtask

   task automatic test_cfg_err;
      int c, w0, h0; bit to;
      w0 = wr_total; h0 = hs_total;
      start_job(2'd2, 4'd7, 8'h10, 3'd1, c);
      wait_done(10, to);
      @(posedge clk); #1;
      n_chk++;
      if (to || done_cyc != c + 2) begin n_fail++; $display("FAIL cfg_done_time: timeout=%0d done at %0d want %0d", to, done_cyc, c + 2); end
      n_chk++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_flag: cfg_err=%b busy=%b want 1 0", cfg_err, busy); end
      n_chk++;
      if (wr_total != w0 || hs_total != h0 || ram_raddr !== 8'h10) begin
         n_fail++; $display("FAIL cfg_noaccess: writes=%0d outs=%0d raddr=%h want 0 0 10", wr_total - w0, hs_total - h0, ram_raddr);
      end
      start_job(2'd0, 4'd0, 8'h10, 3'd5, c);
      wait_done(10, to);
      @(posedge clk); #1;
      n_chk++;
      if (to || cfg_err !== 1'b1 || hs_total != h0) begin
         n_fail++; $display("FAIL cfg_polycnt: timeout=%0d cfg_err=%b outs=%0d want 0 1 0", to, cfg_err, hs_total - h0);
      end
   endtask

   task automatic test_rst_abort;
      int c, w0, w1, dn0; bit to;
      w0 = wr_total; dn0 = done_total;
      s_in_data  = 96'h5;
      s_in_valid = 1'b1;
      start_job(2'd1, 4'd0, 8'h60, 3'd1, c);
      n_chk++;
      if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL abort_cfgclr: cfg_err=%b want 0", cfg_err); end
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wr_total - w0 >= 10) begin to = 1'b0; break; end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      w1 = wr_total;
      n_chk++;
      if (to) begin n_fail++; $display("FAIL abort_reach: 10 writes not reached"); end
      n_chk++;
      if ({busy, done, cfg_err, err_range, ram_wen, s_in_ready, s_out_valid} !== 7'b0 ||
          ram_raddr !== 8'h0 || ram_waddr !== 8'h0 || ram_wdata !== 96'h0) begin
         n_fail++; $display("FAIL abort_outputs: ctrl=%b raddr=%h waddr=%h wdata=%h want all 0",
                            {busy, done, cfg_err, err_range, ram_wen, s_in_ready, s_out_valid},
                            ram_raddr, ram_waddr, ram_wdata);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      n_chk++;
      if (wr_total != w1 || done_total != dn0) begin
         n_fail++; $display("FAIL abort_quiet: writes after reset=%0d done pulses=%0d want 0 0", wr_total - w1, done_total - dn0);
      end
   endtask

   initial begin
      test_reset();
      test_compress_d10();
      test_compress_d1();
      test_decompress_wrap();
      test_unpack_range();
      test_back_to_back_pack12();
      test_cfg_err();
      test_rst_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/kyber_codec_engine.md
Name: kyber_codec_engine

Overview:
- Parametrised, streaming successor to the fixed-size Kyber coder.
- Moves whole polynomials between the coefficient RAM (8 x 12-bit lanes per 96-bit word, 32 words per polynomial) and a valid/ready packed-group stream.
- Per job it applies exactly one of: plain 12-bit pack, 12-bit unpack with range check, Compress_d, or Decompress_d.
- Rank (K), d and base address are chosen per job, so one instance serves pk/sk/c/m for Kyber-512/768/1024 without 6 kbit flat registers.

Parameters:
RAM_AW, 8, RAM address width; all addresses wrap modulo 2^RAM_AW
MAX_POLYS, 4, largest legal poly_cnt
FIFO_DEPTH, 4, output FIFO depth; also the read-credit limit

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  job request; sampled only in IDLE
op  in  2  0=PACK12 (RAM->stream), 1=UNPACK12 (stream->RAM), 2=COMPRESS (RAM->stream), 3=DECOMPRESS (stream->RAM)
d  in  4  compression width; legal values 1,4,5,10,11; ignored for ops 0/1, where d=12 is used
base_addr  in  RAM_AW  first RAM word of the job
poly_cnt  in  3  number of polynomials, 1..MAX_POLYS
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
cfg_err  out  1  illegal config on the last start; held until the next start
err_range  out  1  UNPACK12 saw a coefficient >= 3329; sticky until the next start
ram_raddr  out  RAM_AW  read address; ram_rdata is valid one cycle later
ram_rdata  in  96  read data
ram_wen  out  1  write enable
ram_waddr  out  RAM_AW  write address
ram_wdata  out  96  write data
s_in_valid / s_in_ready / s_in_data  in/out/in  1/1/96  packed input stream
s_out_valid / s_out_ready / s_out_data  out/in/out  1/1/96  packed output stream

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters 0.
- rst mid-job aborts at the next edge: no further RAM writes, FIFO flushed, no done pulse.
- FSM states: IDLE -> CHECK -> RUN -> FIN -> IDLE.
- Job length: words = poly_cnt*32. Word i uses address base_addr+i, wrapping.
- start while busy is ignored.
- CHECK (1 cycle):
  - Illegal config (poly_cnt==0 or >MAX_POLYS; op 2/3 with d outside {1,4,5,10,11}) -> cfg_err=1, then FIN. No RAM or stream activity.
  - Otherwise RUN. cfg_err and err_range clear on every accepted start.
- Packed group: lane j occupies bits [j*dd +: dd], dd = d or 12. Output bits above 8*dd are 0; input bits above 8*dd are ignored.
- Compress, per lane:
  - x' = x-3329 if x >= 3329, else x.
  - out = ((x' << dd) + 1664) / 3329, mod 2^dd (integer divide).
- Decompress, per lane: (y*3329 + 2^(dd-1)) >> dd.
- Read ops (0/2):
  - Issue a read when issued < words and fifo_count + in_flight < FIFO_DEPTH.
  - rdata is registered through the lane stage, then written to the FIFO.
  - First s_out_valid follows the 4th clock edge after the start edge.
  - With s_out_ready held high, throughput is 1 word/cycle.
  - s_out_data/s_out_valid stay stable while s_out_ready=0.
  - FIN is entered after the handshake of the last word.
- Write ops (1/3):
  - s_in_ready=1 in RUN while accepted < words.
  - Each accepted word passes through one registered lane stage.
  - Then ram_wen pulses for 1 cycle with ram_waddr=base_addr+idx.
  - FIN is entered the cycle after the last write.
- UNPACK12: the word is written unchanged even when a lane is >= 3329; err_range is set.
- FIN: done=1 for one cycle, busy falls with it, then IDLE.
- busy=1 from the cycle after start through FIN.

Decomposition:
- Package kyber_codec_pkg:
  - Constants Q=3329, COEF_W=12, LANES=8, WORDS_PER_POLY=32.
  - op enum.
  - d-legality function.
- Sub-module kyber_codec_lane: combinational single-coefficient compress/decompress/range-check with d select, instantiated 8x.
- The FIFO is inline.

Test Plan:
1. COMPRESS d=10, poly_cnt=1, all lanes 1665, s_out_ready=1:
   - 32 output words, each lane 0x200.
   - done exactly 1 cycle after the last handshake.
   - 32 reads, no writes.
2. COMPRESS d=1, lanes {832,833,2496,2497,0,3328,1664,4095}:
   - Outputs {0,1,1,0,0,0,1,0}.
   - s_out_data = 0x46.
3. DECOMPRESS d=4, poly_cnt=3, base_addr=0xF0, lanes {15,1,0,...}:
   - Words written {3121,208,0,...}.
   - 96 writes; addresses wrap 0xFF -> 0x00.
4. UNPACK12 with one lane 3329:
   - Word written unchanged; err_range=1.
   - err_range stays 1 until the next start clears it.
5. PACK12, s_out_ready high 1 cycle in 3:
   - Every word delivered exactly once, in order.
   - Issued reads never exceed handshaken words + 4.
6. Corner cases:
   - COMPRESS d=7: cfg_err=1, done 2 cycles after start, no RAM access.
   - rst asserted at word 10 of UNPACK12: no writes after the reset edge, outputs return to 0.
